// File: rtl/operand_collector.sv
// -----------------------------------------------------------------------------
// operand_collector
//
// Read-side front end for the register file. Holds one decoded instruction,
// drives the register file's two combinational read ports from the latched
// source indices, and waits on a pending-write scoreboard until both sources
// and (for writing instructions) the destination have no outstanding write.
// The operands are then captured and offered downstream on a valid/ready port.
// The scoreboard retires bits by snooping the register file write port.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid and ready are both 1. in_ready depends only on state, flush and
// out_ready, never on in_valid. Once out_valid is 1 the payload (out_op0,
// out_op1, out_rd, out_wb) stays stable until the transfer completes, unless
// flush or reset drops it.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous drop of any held instruction
//   in_valid/in_ready     instruction offer / accept
//   in_rs0, in_rs1, in_rd source and destination register indices
//   in_wb                 instruction writes in_rd
//   rf_r0addr, rf_r1addr  register file read addresses (from latched sources)
//   rf_r0data, rf_r1data  register file read data (combinational, write-first)
//   wb_wena, wb_waddr     snooped register file write port
//   out_valid/out_ready   operand offer / accept
//   out_op0, out_op1      captured operands
//   out_rd, out_wb        destination index and write flag
//   stall_cnt             saturating count of hazard-stall cycles
//   dbg_state             current FSM state (0 EMPTY, 1 HOLD, 2 FULL)
//   dbg_pending           current scoreboard contents
// -----------------------------------------------------------------------------

`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module operand_collector #(
  parameter int REG_ADDR_WIDTH  = `REG_ADDR_WIDTH,
  parameter int DATA_WIDTH      = `DATA_WIDTH,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [REG_ADDR_WIDTH-1:0]         in_rs0,
  input  logic [REG_ADDR_WIDTH-1:0]         in_rs1,
  input  logic [REG_ADDR_WIDTH-1:0]         in_rd,
  input  logic                              in_wb,
  output logic [REG_ADDR_WIDTH-1:0]         rf_r0addr,
  output logic [REG_ADDR_WIDTH-1:0]         rf_r1addr,
  input  logic [DATA_WIDTH-1:0]             rf_r0data,
  input  logic [DATA_WIDTH-1:0]             rf_r1data,
  input  logic                              wb_wena,
  input  logic [REG_ADDR_WIDTH-1:0]         wb_waddr,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-1:0]             out_op0,
  output logic [DATA_WIDTH-1:0]             out_op1,
  output logic [REG_ADDR_WIDTH-1:0]         out_rd,
  output logic                              out_wb,
  output logic [STALL_CNT_WIDTH-1:0]        stall_cnt,
  output logic [1:0]                        dbg_state,
  output logic [(1<<REG_ADDR_WIDTH)-1:0]    dbg_pending
);

  localparam int NREG = 1 << REG_ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                      state_q, state_d;
  logic [REG_ADDR_WIDTH-1:0]   rs0_q, rs0_d;
  logic [REG_ADDR_WIDTH-1:0]   rs1_q, rs1_d;
  logic [REG_ADDR_WIDTH-1:0]   rd_q, rd_d;
  logic                        wb_q, wb_d;
  logic [NREG-1:0]             pending_q, pending_d;
  logic [STALL_CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
  logic [DATA_WIDTH-1:0]       out_op0_q, out_op0_d;
  logic [DATA_WIDTH-1:0]       out_op1_q, out_op1_d;
  logic [REG_ADDR_WIDTH-1:0]   out_rd_q, out_rd_d;
  logic                        out_wb_q, out_wb_d;

  // ---------------------------------------------------------------------------
  // Hazard evaluation
  // ---------------------------------------------------------------------------
  logic [NREG-1:0] wb_hit;
  logic [NREG-1:0] busy;
  logic            hazard;
  logic            in_hold;
  logic            accept;
  logic            capture;
  logic            stall_inc;

  always_comb begin
    wb_hit = '0;
    if (wb_wena) begin
      wb_hit[wb_waddr] = 1'b1;
    end
  end

  // A write landing this cycle counts as resolved: the register file bypasses
  // the write data onto its read ports, so the capture sees the new value.
  assign busy    = pending_q & ~wb_hit;
  assign hazard  = busy[rs0_q] | busy[rs1_q] | (wb_q & busy[rd_q]);
  assign in_hold = (state_q == ST_HOLD);

  assign in_ready  = ~flush & ((state_q == ST_EMPTY) |
                               ((state_q == ST_FULL) & out_ready));
  assign accept    = in_valid & in_ready;
  // flush suppresses both a capture and the stall count in its cycle.
  assign capture   = in_hold & ~hazard & ~flush;
  assign stall_inc = in_hold & hazard & ~flush;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    rs0_d       = rs0_q;
    rs1_d       = rs1_q;
    rd_d        = rd_q;
    wb_d        = wb_q;
    stall_cnt_d = stall_cnt_q;
    out_op0_d   = out_op0_q;
    out_op1_d   = out_op1_q;
    out_rd_d    = out_rd_q;
    out_wb_d    = out_wb_q;

    // Retire snooped writes; a same-cycle set on the same index overrides.
    pending_d = pending_q & ~wb_hit;
    if (capture && wb_q) begin
      pending_d[rd_q] = 1'b1;
    end

    if (accept) begin
      rs0_d = in_rs0;
      rs1_d = in_rs1;
      rd_d  = in_rd;
      wb_d  = in_wb;
    end

    if (capture) begin
      out_op0_d = rf_r0data;
      out_op1_d = rf_r1data;
      out_rd_d  = rd_q;
      out_wb_d  = wb_q;
    end

    if (stall_inc && (stall_cnt_q != {STALL_CNT_WIDTH{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end

    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept)  state_d = ST_HOLD;
        ST_HOLD:  if (capture) state_d = ST_FULL;
        ST_FULL: begin
          // in_ready is 1 here, so in_valid means the next instruction is
          // latched in this same cycle.
          if (out_ready) begin
            state_d = in_valid ? ST_HOLD : ST_EMPTY;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      rs0_q       <= '0;
      rs1_q       <= '0;
      rd_q        <= '0;
      wb_q        <= 1'b0;
      pending_q   <= '0;
      stall_cnt_q <= '0;
      out_op0_q   <= '0;
      out_op1_q   <= '0;
      out_rd_q    <= '0;
      out_wb_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rs0_q       <= rs0_d;
      rs1_q       <= rs1_d;
      rd_q        <= rd_d;
      wb_q        <= wb_d;
      pending_q   <= pending_d;
      stall_cnt_q <= stall_cnt_d;
      out_op0_q   <= out_op0_d;
      out_op1_q   <= out_op1_d;
      out_rd_q    <= out_rd_d;
      out_wb_q    <= out_wb_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rf_r0addr   = rs0_q;
  assign rf_r1addr   = rs1_q;
  assign out_valid   = (state_q == ST_FULL);
  assign out_op0     = out_op0_q;
  assign out_op1     = out_op1_q;
  assign out_rd      = out_rd_q;
  assign out_wb      = out_wb_q;
  assign stall_cnt   = stall_cnt_q;
  assign dbg_state   = state_q;
  assign dbg_pending = pending_q;

endmodule

// File: tb/tb_operand_collector.sv
// -----------------------------------------------------------------------------
// Testbench for operand_collector: directed multi-cycle sequences, a table of
// no-hazard vectors, and a randomized run against a transaction-level model
// (FIFO of accepted instructions, queue of outstanding writebacks, register
// file array).
// -----------------------------------------------------------------------------
module tb_operand_collector;

  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int SW   = 16;
  localparam int NREG = 1 << AW;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [AW-1:0]   in_rs0, in_rs1, in_rd;
  logic            in_wb;
  logic [AW-1:0]   rf_r0addr, rf_r1addr;
  logic [DW-1:0]   rf_r0data, rf_r1data;
  logic            wb_wena;
  logic [AW-1:0]   wb_waddr;
  logic [DW-1:0]   wb_wdata;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_op0, out_op1;
  logic [AW-1:0]   out_rd;
  logic            out_wb;
  logic [SW-1:0]   stall_cnt;
  logic [1:0]      dbg_state;
  logic [NREG-1:0] dbg_pending;

  always #5 clk = ~clk;

  operand_collector #(
    .REG_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STALL_CNT_WIDTH(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs0(in_rs0), .in_rs1(in_rs1), .in_rd(in_rd), .in_wb(in_wb),
    .rf_r0addr(rf_r0addr), .rf_r1addr(rf_r1addr),
    .rf_r0data(rf_r0data), .rf_r1data(rf_r1data),
    .wb_wena(wb_wena), .wb_waddr(wb_waddr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op0(out_op0), .out_op1(out_op1), .out_rd(out_rd), .out_wb(out_wb),
    .stall_cnt(stall_cnt), .dbg_state(dbg_state), .dbg_pending(dbg_pending)
  );

  // Register file model: combinational reads with write-first bypass.
  logic [DW-1:0] regs [NREG];
  logic          regs_init;

  assign rf_r0data = (wb_wena && wb_waddr == rf_r0addr) ? wb_wdata : regs[rf_r0addr];
  assign rf_r1data = (wb_wena && wb_waddr == rf_r1addr) ? wb_wdata : regs[rf_r1addr];

  always @(posedge clk) begin
    if (regs_init) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= (i < 3) ? DW'(i * 32'h11) : (DW'(i * 32'h11) | 32'hA500_0000);
    end else if (wb_wena) begin
      regs[wb_waddr] <= wb_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  logic [3*AW:0] exp_q[$];   // accepted {rs0, rs1, rd, wb}, in order
  logic [AW-1:0] wq[$];      // registers with an outstanding writeback
  int n_hs = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit in_wq(input logic [AW-1:0] r);
    foreach (wq[i]) if (wq[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks (each starts and ends just after a falling edge)
  // ---------------------------------------------------------------------------
  task automatic issue(input logic [AW-1:0] s0, input logic [AW-1:0] s1,
                       input logic [AW-1:0] d, input logic w);
    in_valid = 1'b1; in_rs0 = s0; in_rs1 = s1; in_rd = d; in_wb = w;
    #1 chk("issue_in_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1 chk("handshake_to_empty", dbg_state, S_EMPTY);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_wena = 1'b1; wb_waddr = a; wb_wdata = d;
    @(negedge clk);
    wb_wena = 1'b0;
  endtask

  // Observes the handshakes of the current cycle and updates the model.
  task automatic process_cycle();
    logic [3*AW:0] e;
    logic [AW-1:0] e_rs0, e_rs1, e_rd;
    logic          e_wb;
    if (out_valid && out_ready) begin
      n_hs++;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rand_unexpected_out actual=out_valid required=no_pending_instr");
      end else begin
        e = exp_q.pop_front();
        {e_rs0, e_rs1, e_rd, e_wb} = e;
        chk("rand_op0", out_op0, regs[e_rs0]);
        chk("rand_op1", out_op1, regs[e_rs1]);
        chk("rand_rd", out_rd, e_rd);
        chk("rand_wb", out_wb, e_wb);
        chk("rand_raw_hazard", in_wq(e_rs0) | in_wq(e_rs1), 1'b0);
        chk("rand_waw_hazard", e_wb & in_wq(e_rd), 1'b0);
        if (e_wb) wq.push_back(e_rd);
      end
    end
    if (in_valid && in_ready) exp_q.push_back({in_rs0, in_rs1, in_rd, in_wb});
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [AW-1:0] rs0, rs1, rd;
    logic          wb;
    logic [DW-1:0] op0, op1;
  } vec_t;

  vec_t tbl[6];

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    bit drained;
    rst_n = 1'b0; regs_init = 1'b1; flush = 1'b0;
    in_valid = 1'b0; in_rs0 = '0; in_rs1 = '0; in_rd = '0; in_wb = 1'b0;
    wb_wena = 1'b0; wb_waddr = '0; wb_wdata = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1; regs_init = 1'b0;
    #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_stall_cnt", stall_cnt, 0);
    chk("reset_pending", dbg_pending, 0);
    chk("reset_rf_r0addr", rf_r0addr, 0);
    chk("reset_out_op0", out_op0, 0);
    @(negedge clk);

    // Basic issue: out_valid on the second cycle after accept.
    issue(5'd1, 5'd2, 5'd3, 1'b1);
    #1 chk("t1_hold_no_valid", out_valid, 1'b0);
    chk("t1_rf_r0addr", rf_r0addr, 5'd1);
    @(negedge clk);
    #1 chk("t1_out_valid", out_valid, 1'b1);
    chk("t1_op0", out_op0, 32'h11);
    chk("t1_op1", out_op1, 32'h22);
    chk("t1_out_rd", out_rd, 5'd3);
    chk("t1_out_wb", out_wb, 1'b1);
    chk("t1_pending3", dbg_pending[3], 1'b1);

    // RAW: consume and accept rs0=3 in the same cycle.
    out_ready = 1'b1; in_valid = 1'b1;
    in_rs0 = 5'd3; in_rs1 = 5'd2; in_rd = 5'd4; in_wb = 1'b0;
    #1 chk("raw_b2b_in_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("raw_stall_state", dbg_state, S_HOLD);
    chk("raw_stall_cnt3", stall_cnt, 3);
    chk("raw_no_valid", out_valid, 1'b0);
    wb_wena = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'h33;
    @(negedge clk);
    wb_wena = 1'b0;
    #1 chk("raw_capture_valid", out_valid, 1'b1);
    chk("raw_bypass_op0", out_op0, 32'h33);
    chk("raw_op1", out_op1, 32'h22);
    chk("raw_pending3_clear", dbg_pending[3], 1'b0);
    chk("raw_stall_frozen", stall_cnt, 3);
    handshake();

    // WAW: set pending[5], then issue another writer of 5.
    issue(5'd0, 5'd0, 5'd5, 1'b1);
    @(negedge clk);
    handshake();
    chk("waw_pending5_set", dbg_pending[5], 1'b1);
    issue(5'd1, 5'd2, 5'd5, 1'b1);
    repeat (2) @(negedge clk);
    #1 chk("waw_stall_state", dbg_state, S_HOLD);
    chk("waw_stall_cnt", stall_cnt, 5);
    wb_wena = 1'b1; wb_waddr = 5'd5; wb_wdata = 32'h55;
    @(negedge clk);
    wb_wena = 1'b0;
    #1 chk("waw_capture", out_valid, 1'b1);
    chk("waw_set_wins", dbg_pending[5], 1'b1);
    chk("waw_op0", out_op0, 32'h11);
    chk("waw_stall_frozen", stall_cnt, 5);
    handshake();

    // Flush while stalled on pending[5].
    issue(5'd5, 5'd0, 5'd10, 1'b0);
    @(negedge clk);
    #1 chk("flush_pre_stall", stall_cnt, 6);
    flush = 1'b1; in_valid = 1'b1; in_rs0 = 5'd1;
    #1 chk("flush_in_ready_low", in_ready, 1'b0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1 chk("flush_state_empty", dbg_state, S_EMPTY);
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_pending_kept", dbg_pending, 32'h0000_0020);
    chk("flush_stall_kept", stall_cnt, 6);
    do_write(5'd5, 32'h5A);
    #1 chk("flush_later_retire", dbg_pending, 0);

    // Backpressure: 4 cycles with out_ready low and a competing offer.
    issue(5'd4, 5'd1, 5'd6, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_rs0 = 5'd9; in_rs1 = 5'd9; in_rd = 5'd9; in_wb = 1'b1;
      out_ready = 1'b0;
      #1;
      chk("bp_in_ready_low", in_ready, 1'b0);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_op0_stable", out_op0, 32'hA500_0044);
      chk("bp_op1_stable", out_op1, 32'h11);
      chk("bp_rd_stable", out_rd, 5'd6);
      @(negedge clk);
    end
    out_ready = 1'b1; in_valid = 1'b1;
    in_rs0 = 5'd2; in_rs1 = 5'd3; in_rd = 5'd7; in_wb = 1'b0;
    #1 chk("bp_b2b_in_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1 chk("bp_next_hold", dbg_state, S_HOLD);
    chk("bp_next_no_valid", out_valid, 1'b0);
    chk("bp_next_r0addr", rf_r0addr, 5'd2);
    @(negedge clk);
    #1 chk("bp_next_op0", out_op0, 32'h22);
    chk("bp_next_op1", out_op1, 32'h33);
    handshake();

    // Table of hazard-free vectors.
    tbl[0] = '{5'd1,  5'd2,  5'd3,  1'b1, 32'h11,        32'h22};
    tbl[1] = '{5'd7,  5'd4,  5'd8,  1'b0, 32'hA500_0077, 32'hA500_0044};
    tbl[2] = '{5'd0,  5'd15, 5'd9,  1'b1, 32'h0,         32'hA500_00FF};
    tbl[3] = '{5'd31, 5'd31, 5'd31, 1'b1, 32'hA500_020F, 32'hA500_020F};
    tbl[4] = '{5'd16, 5'd10, 5'd0,  1'b0, 32'hA500_0110, 32'hA500_00AA};
    tbl[5] = '{5'd3,  5'd9,  5'd12, 1'b1, 32'h33,        32'hA500_0099};
    for (int i = 0; i < 6; i++) begin
      issue(tbl[i].rs0, tbl[i].rs1, tbl[i].rd, tbl[i].wb);
      @(negedge clk);
      #1 chk("tbl_out_valid", out_valid, 1'b1);
      chk("tbl_op0", out_op0, tbl[i].op0);
      chk("tbl_op1", out_op1, tbl[i].op1);
      chk("tbl_rd", out_rd, tbl[i].rd);
      chk("tbl_wb", out_wb, tbl[i].wb);
      chk("tbl_pending_rd", dbg_pending[tbl[i].rd], tbl[i].wb);
      handshake();
      if (tbl[i].wb) do_write(tbl[i].rd, regs[tbl[i].rd]);
      #1 chk("tbl_pending_clear", dbg_pending, 0);
    end

    // Asynchronous reset while FULL with a pending bit and nonzero stall count.
    issue(5'd1, 5'd2, 5'd9, 1'b1);
    @(negedge clk);
    #1 chk("rst_pre_full", dbg_state, S_FULL);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_out_valid", out_valid, 1'b0);
    chk("rst_async_pending", dbg_pending, 0);
    chk("rst_async_stall", stall_cnt, 0);
    chk("rst_async_op0", out_op0, 0);
    chk("rst_async_state", dbg_state, S_EMPTY);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized run: small register range for frequent hazards.
    for (int c = 0; c < 3000; c++) begin
      if (wq.size() > 0 && $urandom_range(0, 2) == 0) begin
        wb_wena = 1'b1; wb_waddr = wq.pop_front(); wb_wdata = $urandom;
      end else begin
        wb_wena = 1'b0;
      end
      in_valid  = ($urandom_range(0, 9) < 7);
      in_rs0    = AW'($urandom_range(0, 3));
      in_rs1    = AW'($urandom_range(0, 3));
      in_rd     = AW'($urandom_range(0, 3));
      in_wb     = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 6);
      #1 process_cycle();
      @(negedge clk);
    end

    // Drain with a bounded budget.
    drained = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < 500 && !drained; c++) begin
      if (wq.size() > 0) begin
        wb_wena = 1'b1; wb_waddr = wq.pop_front(); wb_wdata = $urandom;
      end else begin
        wb_wena = 1'b0;
      end
      out_ready = 1'b1;
      #1 process_cycle();
      @(negedge clk);
      wb_wena = 1'b0;
      #1;
      if (exp_q.size() == 0 && wq.size() == 0 && dbg_state == S_EMPTY) drained = 1'b1;
    end
    chk("rand_drained", drained, 1'b1);
    chk("rand_final_pending", dbg_pending, 0);
    chk("rand_enough_traffic", (n_hs > 200), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_collector.md
# operand_collector

Read-side front end for the register file. It accepts one decoded instruction at a time and drives the register file's two combinational read addresses. A pending-write scoreboard holds the instruction back until both source registers and the destination register are free of outstanding writes. It then captures both operands and presents them downstream with a valid/ready handshake. It snoops the register file write port, the same wena/waddr signals the writeback stage drives, to retire pending bits.

## Interface
Parameters:
- REG_ADDR_WIDTH, default `REG_ADDR_WIDTH: register index width; the scoreboard has 2^REG_ADDR_WIDTH bits.
- DATA_WIDTH, default `DATA_WIDTH: operand width.
- STALL_CNT_WIDTH, default 16: width of the hazard stall counter.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; drops any held instruction.
- in_valid  in  1  instruction offered.
- in_ready  out  1  collector accepts the instruction this cycle.
- in_rs0, in_rs1  in  REG_ADDR_WIDTH each  source register indices.
- in_rd  in  REG_ADDR_WIDTH  destination register index.
- in_wb  in  1  instruction will write in_rd.
- rf_r0addr, rf_r1addr  out  REG_ADDR_WIDTH each  register file read addresses.
- rf_r0data, rf_r1data  in  DATA_WIDTH each  register file read data; combinational, with write-first bypass.
- wb_wena  in  1  register file write enable, snooped.
- wb_waddr  in  REG_ADDR_WIDTH  register file write address, snooped.
- out_valid  out  1  operands valid.
- out_ready  in  1  downstream accepts.
- out_op0, out_op1  out  DATA_WIDTH each  captured operands.
- out_rd  out  REG_ADDR_WIDTH  destination index.
- out_wb  out  1  destination write flag.
- stall_cnt  out  STALL_CNT_WIDTH  saturating count of hazard-stall cycles.

## Operation
- States:
  - EMPTY: nothing held.
  - HOLD: instruction latched, waiting for hazards to clear.
  - FULL: operands captured, out_valid=1.
- in_ready = (state==EMPTY) | (state==FULL & out_ready). Accept occurs when in_valid & in_ready; it latches rs0, rs1, rd and wb, and the next state is HOLD.
- rf_r0addr and rf_r1addr are driven from the latched rs0/rs1 at all times, so they are stable throughout HOLD.
- Effective pending: busy[i] = pending[i] & ~(wb_wena & wb_waddr==i). A same-cycle write counts as resolved, because the register file bypasses wdata onto the read ports.
- Hazard in HOLD = busy[rs0] | busy[rs1] | (wb & busy[rd]). The last term is a WAW check.
- HOLD with no hazard:
  - Capture rf_r0data/rf_r1data into out_op0/out_op1, and rd/wb into out_rd/out_wb.
  - If wb, set pending[rd].
  - Next state is FULL.
- HOLD with hazard: stay in HOLD; stall_cnt increments, saturating at all-ones.
- FULL with out_ready: go to HOLD if in_valid (new instruction latched in the same cycle), otherwise EMPTY.
- FULL without out_ready: hold all outputs stable.
- Scoreboard: pending[wb_waddr] clears when wb_wena=1. If a set and a clear target the same index in the same cycle, the set wins.
- flush (priority over all transitions except reset):
  - Next state is EMPTY; in_ready is forced to 0 that cycle.
  - Pending bits are not modified: writes already dispatched still retire.
  - stall_cnt is unchanged.
  - A capture that would occur in the flush cycle is suppressed, including its pending set.

## Timing
- Reset values: state=EMPTY, pending=0, stall_cnt=0, out_valid=0, out_op0=out_op1=0, out_rd=0, out_wb=0, rf_r0addr=rf_r1addr=0, in_ready=1 (after reset deasserts).
- Latency: an instruction accepted at edge T, with no hazard, gives out_valid=1 after edge T+1 (second cycle).
- Throughput: one instruction per 2 cycles when downstream is always ready.
- Each extra hazard cycle adds exactly 1 cycle of latency.
- A wb_wena to a busy register in cycle C lets capture occur in cycle C, using the bypassed data.
- Reset mid-operation: everything returns to reset values immediately (asynchronous); any held instruction is lost.
- in_ready is combinational from state and out_ready. No output depends combinationally on in_valid.

## Test plan
- Reset then idle: out_valid=0, in_ready=1, stall_cnt=0. Issue rs0=1, rs1=2, rd=3, wb=1 with regs[1]=0x11, regs[2]=0x22. Required: out_valid at second cycle, op0=0x11, op1=0x22, pending[3]=1.
- RAW hazard: after the above, issue rs0=3. Required: held in HOLD with stall_cnt counting. Then drive wb_wena=1, waddr=3, wdata=0x33 for one cycle. Required: capture that same cycle with op0=0x33, pending[3]=0, stall_cnt equal to the stall cycles.
- WAW: with pending[5]=1, issue rd=5, wb=1. Required: stall until the write to 5 retires, then pending[5]=1 again, because set wins over the same-cycle clear.
- Backpressure: out_ready=0 for 4 cycles while FULL. Required: outputs stable, in_ready=0. Then raise out_ready with in_valid=1. Required: back-to-back accept, and the next instruction goes to HOLD.
- Flush in HOLD with a hazard pending. Required: state EMPTY next cycle, out_valid=0, scoreboard unchanged. A later write to that register clears its bit.
- Assert rst_n low mid-FULL. Required: out_valid=0, pending=0, stall_cnt=0 without waiting for a clock edge.
